// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: state encoding and read FIFO sizing shared by the burst controller
package mem_burst_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;
  localparam int RD_FIFO_DEPTH = 4;
  localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;
endpackage

// File: rtl/mem_burst_if.sv
// mem_burst_if: single-port memory bus between the burst controller and a memory
interface mem_burst_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
) ();
  logic              wr;
  logic              rd;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] data;
  logic [DWIDTH-1:0] rddata;
  logic              rddatavalid;
  modport master (output wr, rd, addr, data, input rddata, rddatavalid);
  modport slave (input wr, rd, addr, data, output rddata, rddatavalid);
endinterface

// File: rtl/mem_burst_fifo.sv
// mem_burst_fifo: synchronous read-data FIFO with occupancy count
module mem_burst_fifo
  import mem_burst_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] din_i,
  input  logic              pop_i,
  output logic [DWIDTH-1:0] dout_o,
  output logic [CNT_W-1:0]  count_o
);
  localparam int PW = CNT_W - 1;
  logic [DWIDTH-1:0] buf_q [RD_FIFO_DEPTH];
  logic [DWIDTH-1:0] buf_d [RD_FIFO_DEPTH];
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;
  always_comb begin
    do_pop = pop_i && cnt_q != '0;
    do_push = push_i && (cnt_q != CNT_W'(RD_FIFO_DEPTH) || do_pop);
    buf_d = buf_q;
    if (do_push) buf_d[wp_q] = din_i;
    wp_d = wp_q + PW'(do_push);
    rp_d = rp_q + PW'(do_pop);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) buf_q <= buf_d;
  assign dout_o = buf_q[rp_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst read/write controller with credit-limited reads into a small FIFO
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int LWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [AWIDTH-1:0] cmd_addr_i,
  input  logic [LWIDTH-1:0] cmd_len_i,
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic              rdata_valid_o,
  input  logic              rdata_ready_i,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              done_o,
  mem_burst_if.master       mem_if
);
  localparam int BW = LWIDTH + 1;
  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d, maddr_q, maddr_d, cur_addr;
  logic [DWIDTH-1:0] mdata_q, mdata_d;
  logic [BW-1:0]     beats_q, beats_d, cur_beats;
  logic [CNT_W-1:0]  infl_q, infl_d, fifo_cnt;
  logic              wr_q, wr_d, rd_q, rd_d, wdone_q, wdone_d;
  logic              cmd_hs, credit, rd_go, wr_go, issue, last, ret, pop, rd_done;
  // Reads issue straight from IDLE so the first beat returns three cycles after the command
  always_comb begin
    cmd_hs = state_q == IDLE && cmd_valid_i;
    cur_addr = state_q == IDLE ? cmd_addr_i : addr_q;
    cur_beats = state_q == IDLE ? BW'(cmd_len_i) + BW'(1) : beats_q;
    last = cur_beats == BW'(1);
    credit = ({1'b0, infl_q} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(RD_FIFO_DEPTH);
    ret = mem_if.rddatavalid && infl_q != '0;
    pop = rdata_ready_i && fifo_cnt != '0;
    rd_done = state_q == DRAIN && infl_q == '0 && fifo_cnt == CNT_W'(1) && rdata_ready_i;
    rd_go = ((cmd_hs && !cmd_write_i) || state_q == READ) && credit;
    wr_go = state_q == WRITE && wdata_valid_i;
    issue = rd_go || wr_go;
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd_hs) state_d = cmd_write_i ? WRITE : (rd_go && last) ? DRAIN : READ;
      WRITE: if (wr_go && last) state_d = IDLE;
      READ:  if (rd_go && last) state_d = DRAIN;
      DRAIN: if (rd_done) state_d = IDLE;
    endcase
    addr_d = issue ? cur_addr + AWIDTH'(1) : cmd_hs ? cmd_addr_i : addr_q;
    beats_d = issue ? cur_beats - BW'(1) : cmd_hs ? cur_beats : beats_q;
    maddr_d = issue ? cur_addr : maddr_q;
    mdata_d = wr_go ? wdata_i : '0;
    wr_d = wr_go;
    rd_d = rd_go;
    wdone_d = wr_go && last;
    infl_d = infl_q + CNT_W'(rd_go) - CNT_W'(ret);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      beats_q <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      wdone_q <= 1'b0;
      infl_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      beats_q <= beats_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      wdone_q <= wdone_d;
      infl_q <= infl_d;
    end
  end
  mem_burst_fifo #(.DWIDTH(DWIDTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ret),
    .din_i   (mem_if.rddata),
    .pop_i   (pop),
    .dout_o  (rdata_o),
    .count_o (fifo_cnt)
  );
  assign cmd_ready_o = state_q == IDLE;
  assign wdata_ready_o = state_q == WRITE;
  assign rdata_valid_o = fifo_cnt != '0;
  assign done_o = !rst_i && (wdone_q || rd_done);
  assign mem_if.wr = wr_q;
  assign mem_if.rd = rd_q;
  assign mem_if.addr = maddr_q;
  assign mem_if.data = mdata_q;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed bench for mem_burst_ctrl with a one-cycle-latency memory
module tb_mem_burst_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst, cmd_valid, cmd_write, wdata_valid, rdata_ready, inject;
  logic [7:0] cmd_addr, wdata, rdata;
  logic [3:0] cmd_len;
  logic       cmd_ready, wdata_ready, rdata_valid, done;
  mem_burst_if #(.AWIDTH(8), .DWIDTH(8)) mif ();
  mem_burst_ctrl #(.DWIDTH(8), .AWIDTH(8), .LWIDTH(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_write_i   (cmd_write),
    .cmd_addr_i    (cmd_addr),
    .cmd_len_i     (cmd_len),
    .wdata_valid_i (wdata_valid),
    .wdata_ready_o (wdata_ready),
    .wdata_i       (wdata),
    .rdata_valid_o (rdata_valid),
    .rdata_ready_i (rdata_ready),
    .rdata_o       (rdata),
    .done_o        (done),
    .mem_if        (mif)
  );
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
  always @(posedge clk) begin
    if (mif.wr) mem[mif.addr] <= mif.data;
    mif.rddatavalid <= mif.rd | inject;
    mif.rddata <= mem[mif.addr];
  end
  int wr_cnt = 0, rd_cnt = 0, ovl_cnt = 0, done_cnt = 0, dz_cnt = 0;
  always @(negedge clk) begin
    if (mif.wr) wr_cnt++;
    if (mif.rd) rd_cnt++;
    if (mif.wr && mif.rd) ovl_cnt++;
    if (done) done_cnt++;
    if (!mif.wr && mif.data != 8'h00) dz_cnt++;
  end
  int checks = 0, passed = 0, first_cyc, snap;
  logic [7:0] got [16];
  logic       dn [16];
  logic [7:0] exp8 [8];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic rd_collect(input int n, input int budget);
    int k = 0;
    int cyc = 1;
    first_cyc = 0;
    while (k < n && cyc < budget) begin
      if (rdata_valid && rdata_ready) begin
        if (k == 0) first_cyc = cyc;
        got[k] = rdata;
        dn[k] = done;
        k++;
      end
      step();
      cyc++;
    end
    chk("rd_collect_beats", k, n);
  endtask
  task automatic do_write(input logic [7:0] a, input int len, input logic [7:0] d0);
    logic [7:0] ea, ed;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = 4'(len);
    wdata_valid = 1'b1; wdata = d0;
    step();
    cmd_valid = 1'b0;
    chk("wr_wdata_ready", wdata_ready, 1);
    chk("wr_cmd_busy", cmd_ready, 0);
    for (int i = 0; i <= len; i++) begin
      step();
      ea = a + 8'(i);
      ed = d0 + 8'(i);
      chk("wr_strobe", mif.wr, 1);
      chk("wr_no_rd", mif.rd, 0);
      chk("wr_addr", mif.addr, ea);
      chk("wr_data", mif.data, ed);
      chk("wr_done", done, i == len);
      if (i == len) chk("wr_idle_ready", cmd_ready, 1);
      wdata = d0 + 8'(i + 1);
      if (i == len) wdata_valid = 1'b0;
    end
    step();
    chk("wr_after_strobe", mif.wr, 0);
    chk("wr_after_data", mif.data, 0);
    chk("wr_after_done", done, 0);
  endtask
  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wdata_valid = 0; wdata = 0; rdata_ready = 0; inject = 0;
    step();
    step();
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_wr", mif.wr, 0);
    chk("rst_rd", mif.rd, 0);
    chk("rst_addr", mif.addr, 0);
    chk("rst_data", mif.data, 0);
    snap = wr_cnt;
    do_write(8'h10, 3, 8'hA0);
    chk("w4_count", wr_cnt - snap, 4);
    snap = done_cnt;
    rdata_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_len = 4'd3;
    step();
    cmd_valid = 1'b0;
    chk("r4_first_rd", mif.rd, 1);
    chk("r4_first_addr", mif.addr, 8'h10);
    rd_collect(4, 30);
    chk("r4_latency", first_cyc, 3);
    for (int i = 0; i < 4; i++) begin
      chk("r4_data", got[i], 8'hA0 + 8'(i));
      chk("r4_done", dn[i], i == 3);
    end
    chk("r4_done_count", done_cnt - snap, 1);
    chk("r4_idle", cmd_ready, 1);
    snap = rd_cnt;
    rdata_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 8'h10; cmd_len = 4'd7;
    step();
    cmd_valid = 1'b0;
    repeat (10) step();
    chk("r8_credit_stall", rd_cnt - snap, 4);
    chk("r8_fifo_valid", rdata_valid, 1);
    chk("r8_fifo_head", rdata, 8'hA0);
    chk("r8_no_done", done, 0);
    rdata_ready = 1'b1;
    rd_collect(8, 60);
    exp8 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h4E, 8'h4F, 8'h4C, 8'h4D};
    for (int i = 0; i < 8; i++) begin
      chk("r8_data", got[i], exp8[i]);
      chk("r8_done", dn[i], i == 7);
    end
    chk("r8_rd_total", rd_cnt - snap, 8);
    do_write(8'hFE, 2, 8'hB0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'hFF; cmd_len = 4'd1;
    step();
    cmd_valid = 1'b0;
    rd_collect(2, 20);
    chk("wrap_rd0", got[0], 8'hB1);
    chk("wrap_rd1", got[1], 8'hB2);
    snap = wr_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_len = 4'd1; wdata_valid = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("tog_wdata_ready", wdata_ready, 1);
    wdata_valid = 1'b1; wdata = 8'hC0;
    step();
    chk("tog_wr0", mif.wr, 1);
    chk("tog_addr0", mif.addr, 8'h40);
    chk("tog_data0", mif.data, 8'hC0);
    wdata_valid = 1'b0; wdata = 8'hC1;
    step();
    chk("tog_gap_wr", mif.wr, 0);
    chk("tog_gap_data", mif.data, 0);
    chk("tog_gap_ready", wdata_ready, 1);
    wdata_valid = 1'b1;
    step();
    chk("tog_wr1", mif.wr, 1);
    chk("tog_addr1", mif.addr, 8'h41);
    chk("tog_data1", mif.data, 8'hC1);
    chk("tog_done", done, 1);
    wdata_valid = 1'b0;
    step();
    chk("tog_after_wr", mif.wr, 0);
    chk("tog_count", wr_cnt - snap, 2);
    snap = done_cnt;
    rdata_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_len = 4'd7;
    step();
    cmd_valid = 1'b0;
    step();
    chk("abort_rd2", mif.rd, 1);
    chk("abort_rd2_addr", mif.addr, 8'h11);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_rdata_valid", rdata_valid, 0);
    chk("abort_rd", mif.rd, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    inject = 1'b1;
    step();
    inject = 1'b0;
    step();
    step();
    chk("abort_late_dropped", rdata_valid, 0);
    chk("abort_no_done", done_cnt - snap, 0);
    rdata_ready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 8'h10; cmd_len = 4'd0;
    step();
    cmd_valid = 1'b0;
    rd_collect(1, 20);
    chk("post_abort_data", got[0], 8'hA0);
    chk("post_abort_done", dn[0], 1);
    chk("no_wr_rd_overlap", ovl_cnt, 0);
    chk("data_zero_when_idle", dz_cnt, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
